// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with a power-up valid sweep.
// Optional resolved/mispredict statistics are enabled by defining BRANCH_PREDICTOR_STATS_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | sweep clears valid[ptr] for ptr = 0..LINES-1; not ready; no updates
// RUN   | lookups and execute-stage updates active; held until reset
module branch_predictor #(
  parameter int LINES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_guess,
  input  logic        is_br_guess,
  output logic        pred_taken,
  input  logic [31:0] pc_check,
  input  logic        is_br_check,
  input  logic        br_taken_check,
  input  logic        pred_check,
  output logic        ready,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             sweep_clr;
  logic             upd_en;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [1:0]       ctr_q [LINES];

  logic [IDX_W-1:0] g_idx, c_idx;
  logic [TAG_W-1:0] g_tag, c_tag;
  logic             g_hit, c_hit;
  logic [1:0]       c_ctr;
  logic [1:0]       ctr_next;

  assign g_idx = pc_guess[2+IDX_W-1:2];
  assign g_tag = pc_guess[31:2+IDX_W];
  assign c_idx = pc_check[2+IDX_W-1:2];
  assign c_tag = pc_check[31:2+IDX_W];

  // Lookup reads stored state only, so a same-cycle update is not visible here.
  assign g_hit      = valid_q[g_idx] && (tag_q[g_idx] == g_tag);
  assign pred_taken = ready && is_br_guess && g_hit && ctr_q[g_idx][1];

  assign c_hit = valid_q[c_idx] && (tag_q[c_idx] == c_tag);
  assign c_ctr = ctr_q[c_idx];

  always_comb begin
    ctr_next = c_ctr;
    if (c_hit) begin
      if (br_taken_check) begin
        if (c_ctr != 2'b11) ctr_next = c_ctr + 2'b01;
      end else begin
        if (c_ctr != 2'b00) ctr_next = c_ctr - 2'b01;
      end
    end else begin
      ctr_next = br_taken_check ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sweep_clr = 1'b0;
    ready     = 1'b0;
    upd_en    = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_clr = 1'b1;
        if (ptr_q == LAST_IDX) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_RUN: begin
        ready  = 1'b1;
        upd_en = is_br_check;
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // Tag and counter storage is never reset; the valid sweep makes it unreachable.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (sweep_clr) begin
        valid_q[ptr_q] <= 1'b0;
      end else if (upd_en && !c_hit) begin
        valid_q[c_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && upd_en) begin
      if (!c_hit) tag_q[c_idx] <= c_tag;
      ctr_q[c_idx] <= ctr_next;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] br_cnt_q, mis_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (upd_en) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (pred_check != br_taken_check) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign br_count      = br_cnt_q;
  assign mispred_count = mis_cnt_q;

  logic unused_lsb;
  assign unused_lsb = ^{pc_guess[1:0], pc_check[1:0]};
`else
  assign br_count      = '0;
  assign mispred_count = '0;

  logic unused_in;
  assign unused_in = ^{pc_guess[1:0], pc_check[1:0], pred_check};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (LINES=32); prediction results
// are scoreboarded through a queue, statistics expectations follow BRANCH_PREDICTOR_STATS_EN.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_guess;
  logic        is_br_guess;
  logic        pred_taken;
  logic [31:0] pc_check;
  logic        is_br_check;
  logic        br_taken_check;
  logic        pred_check;
  logic        ready;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int   total = 0;
  int   bad   = 0;
  int   exp_br  = 0;
  int   exp_mis = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  branch_predictor #(.LINES(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_guess      (pc_guess),
    .is_br_guess   (is_br_guess),
    .pred_taken    (pred_taken),
    .pc_check      (pc_check),
    .is_br_check   (is_br_check),
    .br_taken_check(br_taken_check),
    .pred_check    (pred_check),
    .ready         (ready),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input int v);
`ifdef BRANCH_PREDICTOR_STATS_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  // Pops the oldest expected prediction and compares it to the DUT.
  task automatic cmp_pred(input string tag);
    logic e;
    e = exp_q.pop_front();
    check(tag, {31'd0, pred_taken}, {31'd0, e});
  endtask

  task automatic chk(input logic [31:0] pc, input logic taken, input logic pred);
    pc_check       = pc;
    br_taken_check = taken;
    pred_check     = pred;
    is_br_check    = 1'b1;
    @(posedge clk); #1;
    is_br_check = 1'b0;
    exp_br++;
    if (pred != taken) exp_mis++;
  endtask

  task automatic guess(input logic [31:0] pc, input logic gbr, input logic exp, input string tag);
    pc_guess    = pc;
    is_br_guess = gbr;
    exp_q.push_back(exp);
    @(negedge clk);
    cmp_pred(tag);
    @(posedge clk); #1;
    is_br_guess = 1'b0;
  endtask

  // Called just after the reset edge; counts cycles until ready, bounded.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(n), 32'd32);
  endtask

  initial begin
    rst_n          = 1'b0;
    pc_guess       = 32'h80;
    is_br_guess    = 1'b1;
    pc_check       = 32'h80;
    is_br_check    = 1'b1;
    br_taken_check = 1'b1;
    pred_check     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Sweep: check/guess held active throughout INIT must have no effect.
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(1'b0);
      @(negedge clk);
      check("sweep_ready", {31'd0, ready}, 32'd0);
      cmp_pred("sweep_pred");
    end
    @(negedge clk);
    check("ready_cycle33", {31'd0, ready}, 32'd1);
    is_br_check = 1'b0;
    is_br_guess = 1'b0;
    check("stats_init_br", br_count, 32'd0);
    check("stats_init_mis", mispred_count, 32'd0);
    @(posedge clk); #1;
    guess(32'h80, 1'b1, 1'b0, "init_no_alloc");

    // Allocate/predict.
    chk(32'h1000_0040, 1'b1, 1'b0);
    guess(32'h1000_0040, 1'b1, 1'b1, "alloc_hit");
    guess(32'h1000_0044, 1'b1, 1'b0, "alloc_neighbor");
    guess(32'h1000_0040, 1'b0, 1'b0, "not_branch_guess");

    // Alias/tag replacement on index 16.
    chk(32'h40, 1'b1, 1'b0);
    guess(32'h40, 1'b1, 1'b1, "alias_alloc40");
    guess(32'h1000_0040, 1'b1, 1'b0, "alias_evicted");
    chk(32'hC0, 1'b0, 1'b0);
    guess(32'h40, 1'b1, 1'b0, "alias_replaced40");
    guess(32'hC0, 1'b1, 1'b0, "alias_c0_weak_nt");

    // Saturation: alloc 10, then 11, 11, 11; not-taken 10, 01, 00.
    chk(32'h40, 1'b1, 1'b0);
    guess(32'h40, 1'b1, 1'b1, "sat_alloc");
    repeat (3) chk(32'h40, 1'b1, 1'b1);
    chk(32'h40, 1'b0, 1'b1);
    guess(32'h40, 1'b1, 1'b1, "sat_11_to_10");
    chk(32'h40, 1'b0, 1'b1);
    guess(32'h40, 1'b1, 1'b0, "sat_01");
    chk(32'h40, 1'b0, 1'b0);
    guess(32'h40, 1'b1, 1'b0, "sat_00");
    chk(32'h40, 1'b0, 1'b0);
    chk(32'h40, 1'b1, 1'b0);
    guess(32'h40, 1'b1, 1'b0, "floor_then_01");

    // Same-cycle hazard on counter 01: no bypass.
    pc_check       = 32'h40;
    br_taken_check = 1'b1;
    pred_check     = 1'b0;
    is_br_check    = 1'b1;
    pc_guess       = 32'h40;
    is_br_guess    = 1'b1;
    exp_q.push_back(1'b0);
    @(negedge clk);
    cmp_pred("hazard_same_cycle");
    @(posedge clk); #1;
    is_br_check = 1'b0;
    exp_br++;
    exp_mis++;
    exp_q.push_back(1'b1);
    @(negedge clk);
    cmp_pred("hazard_next_cycle");
    @(posedge clk); #1;
    is_br_guess = 1'b0;

    // Non-branch check context must not modify the entry.
    pc_check       = 32'h40;
    br_taken_check = 1'b0;
    is_br_check    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    guess(32'h40, 1'b1, 1'b1, "no_br_hold");
    guess(32'h43, 1'b1, 1'b1, "pc_low_bits_ignored");

    check("stats_run_br", br_count, stat_exp(exp_br));
    check("stats_run_mis", mispred_count, stat_exp(exp_mis));

    // Mid-run reset.
    rst_n       = 1'b0;
    pc_guess    = 32'h40;
    is_br_guess = 1'b1;
    @(posedge clk); #1;
    exp_br  = 0;
    exp_mis = 0;
    exp_q.push_back(1'b0);
    cmp_pred("reset_pred");
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_br", br_count, 32'd0);
    check("reset_mis", mispred_count, 32'd0);
    rst_n = 1'b1;

    // Mid-sweep reset restarts at entry 0.
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("midsweep_len");
    guess(32'h40, 1'b1, 1'b0, "swept_invalid");

    // Statistics: ten checks, three mispredicted.
    for (int i = 0; i < 10; i++) begin
      logic t;
      t = logic'(i % 2);
      chk(32'h200 + 32'(i * 4), t, (i < 3) ? ~t : t);
    end
    check("stats_br10", br_count, stat_exp(10));
    check("stats_mis3", mispred_count, stat_exp(3));
    check("stats_model_br", br_count, stat_exp(exp_br));

    rst_n = 1'b0;
    @(posedge clk); #1;
    check("stats_rst_br", br_count, 32'd0);
    check("stats_rst_mis", mispred_count, 32'd0);
    check("stats_rst_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
